one_unit_mean_seq: RTL and testbench
====================================

ONE_UNIT_MEAN_SEQ -- requirements
Module: one_unit_mean_seq

Interface
REQ-001 SHALL have parameter N_LOG2, default 7, log2 of samples per mean batch (batch = 2^N_LOG2).
REQ-002 SHALL have parameter DW, default 26, sample/mean width (signed).
REQ-003 SHALL have port clk_seq  input  1  sole clock, rising edge.
REQ-004 SHALL have port rstn_seq  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a new batch (honoured in IDLE only).
REQ-006 SHALL have port abort  input  1  discard current batch, return to IDLE.
REQ-007 SHALL have ports in_valid input 1 and in_ready output 1, sample handshake.
REQ-008 SHALL have ports in_z1..in_z4  input  DW each  signed lane samples.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1, result handshake.
REQ-010 SHALL have ports out_m1..out_m4  output  DW each  signed lane means.
REQ-011 SHALL have port busy  output  1  high in ACC or HOLD.
REQ-012 SHALL have port done  output  1  one-cycle pulse on result acceptance.

Function
REQ-013 SHALL implement FSM IDLE -> ACC (start) -> HOLD (final sample accepted) -> IDLE (out_valid & out_ready).
REQ-014 SHALL, on IDLE->ACC, clear all four accumulators and the sample counter in the same edge.
REQ-015 SHALL drive in_ready = 1 only in ACC; a sample is accepted when in_valid & in_ready.
REQ-016 SHALL keep per-lane accumulators DW+N_LOG2 bits wide, sign-extending inputs; no overflow possible.
REQ-017 SHALL count accepted samples 0..2^N_LOG2-1; the accept at count 2^N_LOG2-1 moves to HOLD.
REQ-018 SHALL register out_mK = accK(final) >>> N_LOG2 (arithmetic, truncate toward -inf) and assert out_valid on the cycle after the final accept.
REQ-019 SHALL hold out_mK and out_valid stable in HOLD until out_ready; done pulses on the acceptance edge's following cycle.
REQ-020 SHALL ignore start while busy; abort in any state returns to IDLE next edge, clears out_valid, no done.
REQ-021 SHALL give abort priority over a simultaneous final accept or out_ready.
REQ-022 SHALL retain out_mK values after leaving HOLD until next final accept (out_valid low).
REQ-023 SHALL, with start and abort both high in IDLE, remain in IDLE.

Reset
REQ-024 SHALL, on rstn_seq low, asynchronously force IDLE, counter 0, accumulators 0, out_mK 0, out_valid 0, in_ready 0, busy 0, done 0.
REQ-025 SHALL treat reset mid-ACC/HOLD as full discard; no partial result emitted.

Configuration
REQ-026 SHALL support macro ONE_UNIT_MEAN_SEQ_ROUND_EN: defined -> out_mK = (acc + 2^(N_LOG2-1)) >>> N_LOG2 (round half up); undefined -> plain truncating shift per REQ-018.

Structure
REQ-027 SHALL place FSM state enum, DW, N_LOG2 defaults and accumulator width constant in shared package ica_pkg.
REQ-028 SHALL use one sub-module mean_acc_lane (accumulate, clear, shift/round) instantiated four times.

Verification
REQ-029 SHALL test: 128 samples all lanes = 1 -> out_m = 1, out_valid one cycle after last accept.
REQ-030 SHALL test: ramp 0..127 -> sum 8128 -> out_m = 63 (truncate) / 64 (ROUND_EN).
REQ-031 SHALL test: all lanes = -1 and all = 2^25-1 -> out_m = -1 and 2^25-1, no overflow.
REQ-032 SHALL test: in_valid gaps plus out_ready low 10 cycles -> outputs stable, done once after out_ready.
REQ-033 SHALL test: abort at sample 60, and rstn_seq low at sample 100 -> IDLE, out_valid 0, no done; next batch correct.
REQ-034 SHALL test: start pulsed during ACC/HOLD -> ignored, counter and result unaffected.

Source files
------------

// File: rtl/ica_pkg.sv
// Shared types and default sizing for the batch-mean sequencer and its lane accumulators.
package ica_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int DW_DEF     = 26;
  localparam int N_LOG2_DEF = 7;
  // Wide enough to sum 2^N_LOG2 full-scale samples without overflow.
  localparam int ACC_W_DEF  = DW_DEF + N_LOG2_DEF;

endpackage

// File: rtl/mean_acc_lane.sv
// One lane of the batch mean: sign-extending accumulator plus registered scaled result.
// Optional build macro ONE_UNIT_MEAN_SEQ_ROUND_EN selects round-half-up instead of truncation.
module mean_acc_lane
  import ica_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int DW     = DW_DEF,
  parameter int AW     = ACC_W_DEF
) (
  input  logic                 clk_seq,
  input  logic                 rstn_seq,
  input  logic                 clr,
  input  logic                 acc_en,
  input  logic                 load,
  input  logic signed [DW-1:0] sample,
  output logic signed [DW-1:0] mean_p1
);

`ifdef ONE_UNIT_MEAN_SEQ_ROUND_EN
  localparam logic signed [AW-1:0] HALF = AW'((1 << N_LOG2) >> 1);
`endif

  logic signed [AW-1:0] acc_p0;
  logic signed [AW-1:0] sample_ext;
  logic signed [AW-1:0] acc_nxt;

  function automatic logic signed [DW-1:0] scale_mean(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] t;
`ifdef ONE_UNIT_MEAN_SEQ_ROUND_EN
    t = (a + HALF) >>> N_LOG2;
`else
    t = a >>> N_LOG2;
`endif
    return t[DW-1:0];
  endfunction

  assign sample_ext = AW'(sample);
  assign acc_nxt    = acc_p0 + sample_ext;

  // Stage p0: running sum of accepted samples
  always_ff @(posedge clk_seq or negedge rstn_seq) begin
    if (!rstn_seq) begin
      acc_p0 <= '0;
    end else if (clr) begin
      acc_p0 <= '0;
    end else if (acc_en) begin
      acc_p0 <= acc_nxt;
    end
  end

  // Stage p1: final sum including the last sample, scaled down to a mean
  always_ff @(posedge clk_seq or negedge rstn_seq) begin
    if (!rstn_seq) begin
      mean_p1 <= '0;
    end else if (load) begin
      mean_p1 <= scale_mean(acc_nxt);
    end
  end

endmodule

// File: rtl/one_unit_mean_seq.sv
// Four-lane batch-mean sequencer: accumulates 2^N_LOG2 samples per lane, then holds the means.
// Optional build macro ONE_UNIT_MEAN_SEQ_ROUND_EN selects round-half-up in the lanes.
module one_unit_mean_seq
  import ica_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic                 clk_seq,
  input  logic                 rstn_seq,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_z1,
  input  logic signed [DW-1:0] in_z2,
  input  logic signed [DW-1:0] in_z3,
  input  logic signed [DW-1:0] in_z4,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_m1,
  output logic signed [DW-1:0] out_m2,
  output logic signed [DW-1:0] out_m3,
  output logic signed [DW-1:0] out_m4,
  output logic                 busy,
  output logic                 done
);

  localparam int            CW   = (N_LOG2 > 0) ? N_LOG2 : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << N_LOG2) - 1);

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic                accept;
  logic                final_acc;
  logic                clr;
  logic                vld_p1;
  logic                done_p1;
  logic signed [DW-1:0] z [4];
  logic signed [DW-1:0] m [4];

  assign in_ready  = (state == ST_ACC);
  // Abort outranks both a final accept and a result handshake.
  assign accept    = in_valid & in_ready & ~abort;
  assign final_acc = accept & (cnt == LAST);
  assign clr       = (state == ST_IDLE) & start & ~abort;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (clr) state_nxt = ST_ACC;
      ST_ACC: begin
        if (abort)          state_nxt = ST_IDLE;
        else if (final_acc) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (abort || out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_seq or negedge rstn_seq) begin
    if (!rstn_seq) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_seq or negedge rstn_seq) begin
    if (!rstn_seq) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Stage p1: result valid and acceptance pulse
  always_ff @(posedge clk_seq or negedge rstn_seq) begin
    if (!rstn_seq) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= (state_nxt == ST_HOLD);
      done_p1 <= (state == ST_HOLD) & out_ready & ~abort;
    end
  end

  assign out_valid = vld_p1;
  assign done      = done_p1;
  assign busy      = (state != ST_IDLE);

  assign z[0] = in_z1;
  assign z[1] = in_z2;
  assign z[2] = in_z3;
  assign z[3] = in_z4;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    mean_acc_lane #(
      .N_LOG2 (N_LOG2),
      .DW     (DW),
      .AW     (DW + N_LOG2)
    ) u_lane (
      .clk_seq  (clk_seq),
      .rstn_seq (rstn_seq),
      .clr      (clr),
      .acc_en   (accept),
      .load     (final_acc),
      .sample   (z[g]),
      .mean_p1  (m[g])
    );
  end

  assign out_m1 = m[0];
  assign out_m2 = m[1];
  assign out_m3 = m[2];
  assign out_m4 = m[3];

endmodule

// File: tb/tb_one_unit_mean_seq.sv
// Directed bench for one_unit_mean_seq: table of batch vectors plus abort/reset/start corner sequences.
module tb_one_unit_mean_seq;

  localparam int DW    = 26;
  localparam int N     = 7;
  localparam int BATCH = 128;

  typedef struct packed {
    int kind;  // 0 = constant per lane, 1 = ramp base+i
    int v1; int v2; int v3; int v4;
    int e1; int e2; int e3; int e4;
  } vec_t;

  logic clk_seq = 1'b0;
  logic rstn_seq = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, busy, done;
  logic signed [DW-1:0] in_z1 = '0, in_z2 = '0, in_z3 = '0, in_z4 = '0;
  logic signed [DW-1:0] out_m1, out_m2, out_m3, out_m4;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  vec_t vecs [6];

  one_unit_mean_seq #(.N_LOG2(N), .DW(DW)) dut (
    .clk_seq   (clk_seq),
    .rstn_seq  (rstn_seq),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_z1     (in_z1),
    .in_z2     (in_z2),
    .in_z3     (in_z3),
    .in_z4     (in_z4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_m1    (out_m1),
    .out_m2    (out_m2),
    .out_m3    (out_m3),
    .out_m4    (out_m4),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_seq = ~clk_seq;

  always @(negedge clk_seq) if (done) done_cnt++;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_seq);
    #1;
  endtask

  task automatic set_lanes(input vec_t r, input int i);
    int d;
    d = (r.kind == 1) ? i : 0;
    in_z1 = DW'(r.v1 + d);
    in_z2 = DW'(r.v2 + d);
    in_z3 = DW'(r.v3 + d);
    in_z4 = DW'(r.v4 + d);
  endtask

  task automatic feed(input vec_t r, input int i0, input int n, input bit gaps);
    for (int i = i0; i < i0 + n; i++) begin
      if (gaps && (i % 7 == 3)) begin
        in_valid = 1'b0;
        step();
      end
      set_lanes(r, i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_means(input string tag, input vec_t r);
    check({tag, "_m1"}, out_m1, r.e1);
    check({tag, "_m2"}, out_m2, r.e2);
    check({tag, "_m3"}, out_m3, r.e3);
    check({tag, "_m4"}, out_m4, r.e4);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_handshake(input string tag, input vec_t r, input int hold);
    int d0;
    d0 = done_cnt;
    for (int h = 0; h < hold; h++) begin
      step();
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_m1"}, out_m1, r.e1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_busy"}, busy, 0);
    check({tag, "_done_hi"}, done, 1);
    step();
    check({tag, "_done_lo"}, done, 0);
    check({tag, "_done_once"}, done_cnt, d0 + 1);
    check_means({tag, "_retain"}, r);
  endtask

  task automatic run_batch(input string tag, input vec_t r, input bit gaps, input int hold);
    do_start();
    check({tag, "_busy"}, busy, 1);
    check({tag, "_in_ready"}, in_ready, 1);
    feed(r, 0, BATCH, gaps);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_ready_lo"}, in_ready, 0);
    check_means(tag, r);
    finish_handshake(tag, r, hold);
  endtask

  initial begin
    vec_t r;
    int d0;
    vecs[0] = '{kind: 0, v1: 1, v2: 1, v3: 1, v4: 1, e1: 1, e2: 1, e3: 1, e4: 1};
`ifdef ONE_UNIT_MEAN_SEQ_ROUND_EN
    vecs[1] = '{kind: 1, v1: 0, v2: -128, v3: 100, v4: -64, e1: 64, e2: -64, e3: 164, e4: 0};
    vecs[5] = '{kind: 1, v1: 33554304, v2: -33554432, v3: 1000, v4: -1000,
                e1: 33554368, e2: -33554368, e3: 1064, e4: -936};
`else
    vecs[1] = '{kind: 1, v1: 0, v2: -128, v3: 100, v4: -64, e1: 63, e2: -65, e3: 163, e4: -1};
    vecs[5] = '{kind: 1, v1: 33554304, v2: -33554432, v3: 1000, v4: -1000,
                e1: 33554367, e2: -33554369, e3: 1063, e4: -937};
`endif
    vecs[2] = '{kind: 0, v1: -1, v2: -1, v3: -1, v4: -1, e1: -1, e2: -1, e3: -1, e4: -1};
    vecs[3] = '{kind: 0, v1: 33554431, v2: 33554431, v3: 33554431, v4: 33554431,
                e1: 33554431, e2: 33554431, e3: 33554431, e4: 33554431};
    vecs[4] = '{kind: 0, v1: -33554432, v2: 0, v3: 5, v4: -5,
                e1: -33554432, e2: 0, e3: 5, e4: -5};

    #3;
    check("rst_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_m1", out_m1, 0);
    check("rst_m4", out_m4, 0);
    step();
    rstn_seq = 1'b1;
    step();

    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle_busy", busy, 0);
    check("start_abort_idle_ready", in_ready, 0);

    for (int k = 0; k < 6; k++) begin
      run_batch($sformatf("vec%0d", k), vecs[k], (k == 1 || k == 3), (k == 1) ? 10 : 0);
    end

    // abort at sample 60
    r = vecs[0];
    d0 = done_cnt;
    do_start();
    feed(r, 0, 60, 1'b0);
    set_lanes(r, 60);
    in_valid = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort60_busy", busy, 0);
    check("abort60_valid", out_valid, 0);
    check("abort60_ready", in_ready, 0);
    check_means("abort60_keep", vecs[5]);
    repeat (3) step();
    check("abort60_no_done", done_cnt, d0);
    run_batch("after_abort", vecs[0], 1'b0, 0);

    // abort coinciding with the final accept
    r = vecs[2];
    do_start();
    feed(r, 0, 127, 1'b0);
    set_lanes(r, 127);
    in_valid = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort_final_valid", out_valid, 0);
    check("abort_final_busy", busy, 0);
    check_means("abort_final_keep", vecs[0]);

    // abort coinciding with out_ready in HOLD
    d0 = done_cnt;
    do_start();
    feed(r, 0, BATCH, 1'b0);
    check("abort_hold_valid_pre", out_valid, 1);
    abort = 1'b1;
    out_ready = 1'b1;
    step();
    abort = 1'b0;
    out_ready = 1'b0;
    check("abort_hold_valid", out_valid, 0);
    check("abort_hold_busy", busy, 0);
    step();
    check("abort_hold_no_done", done_cnt, d0);

    // reset at sample 100
    r = vecs[1];
    d0 = done_cnt;
    do_start();
    feed(r, 0, 100, 1'b0);
    rstn_seq = 1'b0;
    #1;
    check("rst100_valid", out_valid, 0);
    check("rst100_busy", busy, 0);
    check("rst100_ready", in_ready, 0);
    check("rst100_m1", out_m1, 0);
    step();
    rstn_seq = 1'b1;
    step();
    check("rst100_no_done", done_cnt, d0);
    run_batch("after_rst", vecs[1], 1'b0, 0);

    // start held during ACC and pulsed during HOLD
    r = vecs[5];
    do_start();
    feed(r, 0, 50, 1'b0);
    start = 1'b1;
    feed(r, 50, BATCH - 50, 1'b0);
    check("startglitch_valid", out_valid, 1);
    check_means("startglitch", r);
    step();
    start = 1'b0;
    check("startglitch_hold_valid", out_valid, 1);
    check_means("startglitch_hold", r);
    finish_handshake("startglitch", r, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
